// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight,
// and hands each returned word to decode through a one-entry valid/stall buffer.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] fetched_instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_misaligned_o
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] pc_q;
  logic        kill_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        misaligned_q;

  logic        consume;
  logic        buffer_free;
  logic        granted;
  logic        resp;
  logic        target_aligned;
  logic        accept_resp;

  assign consume        = valid_q && !stall_i;
  assign buffer_free    = !valid_q || consume;
  assign imem_req_o     = !rst_i && (state_q == ST_REQ) && buffer_free;
  assign granted        = imem_req_o && imem_gnt_i;
  assign resp           = (state_q == ST_WAIT) && imem_rvalid_i;
  assign target_aligned = (redirect_pc_i[1:0] == 2'b00);
  assign accept_resp    = resp && !kill_q && !redirect_i;

  assign imem_addr_o        = pc_q;
  assign fetched_instr_o    = instr_q;
  assign instr_pc_o         = instr_pc_q;
  assign instr_valid_o      = valid_q;
  assign fetch_misaligned_o = misaligned_q;

  // A granted request always runs to its response, so a misaligned redirect only
  // reaches HALT once the outstanding (killed) response has drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (granted) begin
          state_d = ST_WAIT;
        end else if (redirect_i && !target_aligned) begin
          state_d = ST_HALT;
        end
      end
      ST_WAIT: begin
        if (resp) begin
          if (redirect_i) begin
            state_d = target_aligned ? ST_REQ : ST_HALT;
          end else begin
            state_d = misaligned_q ? ST_HALT : ST_REQ;
          end
        end
      end
      ST_HALT: begin
        if (redirect_i && target_aligned) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (imem_rvalid_i) begin
        kill_q <= 1'b0;
      end else if (redirect_i) begin
        kill_q <= 1'b1;
      end
    end else if (granted && redirect_i) begin
      kill_q <= 1'b1;
    end
  end

  // Redirect outranks both a returning response and a consume in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      instr_pc_q   <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        valid_q <= 1'b0;
        if (target_aligned) begin
          pc_q         <= redirect_pc_i;
          misaligned_q <= 1'b0;
        end else begin
          misaligned_q <= 1'b1;
        end
      end else if (accept_resp) begin
        instr_q    <= imem_rdata_i;
        instr_pc_q <= pc_q;
        pc_q       <= pc_q + 32'd4;
        valid_q    <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
